// File: rtl/wasm_pkg.sv
// wasm_pkg: shared constants and state types for the WebAssembly image loader.
// Holds header bytes, section ids, parser/loader state enums and defaults.
package wasm_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int ROM_BYTES_DEF = 256;

  // "\0asm" magic followed by version 1, byte 0 in the low octet
  localparam logic [63:0] WASM_HDR = 64'h0000_0001_6D73_6100;

  typedef enum logic [7:0] {
    SEC_CUSTOM = 8'd0,
    SEC_TYPE   = 8'd1,
    SEC_IMPORT = 8'd2,
    SEC_FUNC   = 8'd3,
    SEC_TABLE  = 8'd4,
    SEC_MEM    = 8'd5,
    SEC_GLOBAL = 8'd6,
    SEC_EXPORT = 8'd7,
    SEC_START  = 8'd8,
    SEC_ELEM   = 8'd9,
    SEC_CODE   = 8'd10,
    SEC_DATA   = 8'd11
  } sec_id_e;

  typedef enum logic [3:0] {
    P_HDR,
    P_SEC_ID,
    P_SEC_SIZE,
    P_SKIP,
    P_CODE_CNT,
    P_BODY_SIZE,
    P_LOCAL_CNT,
    P_LOCAL_ENT,
    P_LOCAL_TYPE,
    P_DONE
  } pstate_e;

  typedef enum logic [1:0] {
    L_IDLE,
    L_REQ,
    L_WR,
    L_STOP
  } lstate_e;

  function automatic logic [7:0] hdr_byte(input logic [2:0] i);
    return WASM_HDR[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wasm_image_loader_if.sv
// ROM read bus: master drives rom_addr/rom_read_en,
// slave answers with rom_data and a one-cycle rom_ready pulse.
interface wasm_image_loader_if
  import wasm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_read_en;
  logic [7:0]        rom_data;
  logic              rom_ready;

  modport master (
    output rom_addr, rom_read_en,
    input  rom_data, rom_ready
  );

  modport slave (
    input  rom_addr, rom_read_en,
    output rom_data, rom_ready
  );
endinterface

// File: rtl/wasm_image_loader_leb.sv
// leb128_decoder: unsigned LEB128 accumulator, one byte per valid_i.
// value_o/done_o/overflow_o are valid in the cycle of the byte; clear_i restarts.
module leb128_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] value_o,
  output logic        done_o,
  output logic        overflow_o
);

  logic [31:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  sh;

  always_comb begin
    sh         = 6'(cnt_q) * 6'd7;
    value_o    = acc_q | (32'(byte_i[6:0]) << sh);
    done_o     = valid_i & ~byte_i[7];
    // a fifth byte that still continues means a sixth byte follows
    overflow_o = valid_i & byte_i[7] & (cnt_q == 3'd4);
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (clear_i || done_o || overflow_o) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (valid_i) begin
      acc_d = value_o;
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wasm_image_loader.sv
// wasm_image_loader: copies ROM[0..ROM_BYTES-1] to memory and parses the wasm
// module for body 0's first opcode. Ports: rom bus, mem write bus, status.
module wasm_image_loader
  import wasm_pkg::*;
#(
  parameter int ROM_BYTES = ROM_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  wasm_image_loader_if.master rom,
  input  logic               mem_grant,
  output wire [ADDR_W-1:0]   mem_addr,
  output wire [7:0]          mem_data,
  output wire                mem_write_en,
  output logic               rom_mapped,
  output logic [ADDR_W-1:0]  first_instruction,
  output logic               load_error
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROM_BYTES - 1);

  lstate_e           ls_q, ls_d;
  pstate_e           ps_q, ps_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        id_q, id_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] fi_q, fi_d;
  logic              err_q, err_d;
  logic              map_q, map_d;

  logic              rd_en, we, cap, last, in_code;
  logic [ADDR_W-1:0] nxt;
  logic              leb_en, leb_done, leb_ovf;
  logic [31:0]       leb_val;

  assign cap     = (ls_q == L_REQ) && rom.rom_ready;
  assign last    = (addr_q == LAST);
  assign nxt     = addr_q + 1'b1;
  assign in_code = ps_q inside {P_CODE_CNT, P_BODY_SIZE, P_LOCAL_CNT,
                                P_LOCAL_ENT, P_LOCAL_TYPE};
  assign leb_en  = cap && (ps_q inside {P_SEC_SIZE, P_CODE_CNT, P_BODY_SIZE,
                                        P_LOCAL_CNT, P_LOCAL_ENT});

  leb128_decoder u_leb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (ls_q == L_IDLE),
    .valid_i    (leb_en),
    .byte_i     (rom.rom_data),
    .value_o    (leb_val),
    .done_o     (leb_done),
    .overflow_o (leb_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ls_q   <= L_IDLE;
      ps_q   <= P_HDR;
      addr_q <= '0;
      byte_q <= '0;
      id_q   <= '0;
      end_q  <= '0;
      cnt_q  <= '0;
      fi_q   <= '0;
      err_q  <= 1'b0;
      map_q  <= 1'b0;
    end else begin
      ls_q   <= ls_d;
      ps_q   <= ps_d;
      addr_q <= addr_d;
      byte_q <= byte_d;
      id_q   <= id_d;
      end_q  <= end_d;
      cnt_q  <= cnt_d;
      fi_q   <= fi_d;
      err_q  <= err_d;
      map_q  <= map_d;
    end
  end

  // a parse error is visible in L_WR, so the faulty byte is never written
  always_comb begin
    ls_d = ls_q;
    unique case (ls_q)
      L_IDLE: ls_d = L_REQ;
      L_REQ:  if (rom.rom_ready) ls_d = L_WR;
      L_WR: begin
        if (err_q)          ls_d = L_STOP;
        else if (mem_grant) ls_d = last ? L_STOP : L_REQ;
      end
      default: ls_d = L_STOP;
    endcase
  end

  always_comb begin
    rd_en = (ls_q == L_REQ);
    we    = (ls_q == L_WR) && mem_grant && !err_q;
  end

  always_comb begin
    addr_d = addr_q;
    byte_d = byte_q;
    map_d  = map_q;
    if (cap) byte_d = rom.rom_data;
    if (we) begin
      if (last) map_d = 1'b1;
      else      addr_d = nxt;
    end
  end

  always_comb begin
    ps_d  = ps_q;
    id_d  = id_q;
    end_d = end_q;
    cnt_d = cnt_q;
    fi_d  = fi_q;
    err_d = err_q;
    if (cap) begin
      unique case (ps_q)
        P_HDR: begin
          if (rom.rom_data != hdr_byte(addr_q[2:0])) err_d = 1'b1;
          else if (addr_q[2:0] == 3'd7)              ps_d = P_SEC_ID;
        end
        P_SEC_ID: begin
          id_d = rom.rom_data;
          ps_d = P_SEC_SIZE;
        end
        P_SEC_SIZE: if (leb_done) begin
          end_d = nxt + ADDR_W'(leb_val);
          if (leb_val == 32'd0)    ps_d = P_SEC_ID;
          else if (id_q == SEC_CODE) ps_d = P_CODE_CNT;
          else                     ps_d = P_SKIP;
        end
        P_SKIP: if (nxt == end_q) ps_d = P_SEC_ID;
        P_CODE_CNT: if (leb_done) begin
          if (leb_val == 32'd0) err_d = 1'b1;
          else                  ps_d = P_BODY_SIZE;
        end
        P_BODY_SIZE: if (leb_done) ps_d = P_LOCAL_CNT;
        P_LOCAL_CNT: if (leb_done) begin
          if (leb_val == 32'd0) begin
            fi_d = nxt;
            ps_d = P_DONE;
          end else begin
            cnt_d = leb_val;
            ps_d  = P_LOCAL_ENT;
          end
        end
        P_LOCAL_ENT: if (leb_done) ps_d = P_LOCAL_TYPE;
        P_LOCAL_TYPE: begin
          cnt_d = cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            fi_d = nxt;
            ps_d = P_DONE;
          end else begin
            ps_d = P_LOCAL_ENT;
          end
        end
        default: ;
      endcase
      if (leb_ovf) err_d = 1'b1;
      // code section ran out before body 0's locals were complete
      if (in_code && ps_d != P_DONE && nxt == end_q) ps_d = P_SEC_ID;
    end
    if (we && last && ps_q != P_DONE) err_d = 1'b1;
  end

  assign rom.rom_addr      = addr_q;
  assign rom.rom_read_en   = rd_en;
  assign mem_addr          = mem_grant ? addr_q : {ADDR_W{1'bz}};
  assign mem_data          = mem_grant ? byte_q : 8'bzzzz_zzzz;
  assign mem_write_en      = mem_grant ? we : 1'bz;
  assign rom_mapped        = map_q;
  assign first_instruction = fi_q;
  assign load_error        = err_q;

endmodule

// File: tb/tb_wasm_image_loader.sv
// tb_wasm_image_loader: directed images against a ROM responder and memory
// model; hand-computed first_instruction/error/copy expectations.
module tb_wasm_image_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_grant = 1'b1;
  logic        rom_mapped, load_error;
  logic [31:0] first_instruction;
  wire  [31:0] mem_addr;
  wire  [7:0]  mem_data;
  wire         mem_we;

  wasm_image_loader_if #(.ADDR_W(32)) rom_bus ();

  wasm_image_loader #(.ROM_BYTES(256), .ADDR_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rom               (rom_bus),
    .mem_grant         (mem_grant),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .mem_write_en      (mem_we),
    .rom_mapped        (rom_mapped),
    .first_instruction (first_instruction),
    .load_error        (load_error)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  logic [7:0] mem [256];
  int wcnt [256];
  int n_run = 0, n_fail = 0;
  int cyc = 0, reads = 0, writes = 0, wait_cnt = 0;
  int t_ff = -1, t_map = -1, t_err = -1, t_cap1 = -1;
  int bad_rd = 0, bad_we = 0;
  logic stall_mon = 1'b0, map_p = 1'b0, err_p = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tb();
    foreach (mem[i]) begin
      mem[i]  = 8'hEE;
      wcnt[i] = 0;
    end
    reads = 0; writes = 0; bad_rd = 0; bad_we = 0;
    t_ff = -1; t_map = -1; t_err = -1; t_cap1 = -1;
  endtask

  function automatic int copy_diffs();
    int d = 0;
    foreach (rom[i]) if (mem[i] !== rom[i] || wcnt[i] != 1) d++;
    return d;
  endfunction

  task automatic put_hdr();
    logic [7:0] h [8];
    h = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};
    foreach (rom[i]) rom[i] = 8'h00;
    for (int i = 0; i < 8; i++) rom[8'(i)] = h[i];
  endtask

  // code section at a: 1 body, 1 local group (1 x i32), first opcode at a+7
  task automatic put_code(input int a);
    logic [7:0] c [11];
    c = '{8'h0A, 8'h09, 8'h01, 8'h07, 8'h01, 8'h01, 8'h7F,
          8'h41, 8'h2A, 8'h1A, 8'h0B};
    for (int i = 0; i < 11; i++) rom[8'(a + i)] = c[i];
  endtask

  // header, type sec (8..14), custom filler (15..40), code at 41 -> 0x30
  task automatic img_basic();
    put_hdr();
    rom[8] = 8'h01; rom[9] = 8'h05;
    rom[10] = 8'h01; rom[11] = 8'h60;
    rom[15] = 8'h00; rom[16] = 8'h18;
    for (int i = 17; i < 41; i++) rom[8'(i)] = 8'(i);
    put_code(41);
  endtask

  // custom sec of 128 bytes (size 80 01), code at 139 -> 0x92
  task automatic img_custom();
    put_hdr();
    rom[8] = 8'h00; rom[9] = 8'h80; rom[10] = 8'h01;
    for (int i = 11; i < 139; i++) rom[8'(i)] = 8'hFF;
    put_code(139);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_tb();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(rom_mapped || load_error) && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 6000), 32'd1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rd_en"}, 32'(rom_bus.rom_read_en), 32'd0);
    chk({tag, "_addr"}, rom_bus.rom_addr, 32'd0);
    chk({tag, "_mapped"}, 32'(rom_mapped), 32'd0);
    chk({tag, "_err"}, 32'(load_error), 32'd0);
    chk({tag, "_fi"}, first_instruction, 32'd0);
  endtask

  // ROM: answers a held request on its third cycle with a one-cycle pulse
  initial begin
    rom_bus.rom_ready = 1'b0;
    rom_bus.rom_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      rom_bus.rom_ready = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (rom_bus.rom_read_en && wait_cnt == 2) begin
        rom_bus.rom_data  = rom[rom_bus.rom_addr[7:0]];
        rom_bus.rom_ready = 1'b1;
        wait_cnt = 0;
        reads++;
      end else if (rom_bus.rom_read_en) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // memory model and event timestamps, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    cyc++;
    if (mem_we === 1'b1) begin
      mem[mem_addr[7:0]] = mem_data;
      wcnt[mem_addr[7:0]]++;
      writes++;
      if (mem_addr == 32'hFF) t_ff = cyc;
    end
    if (rom_bus.rom_ready && rom_bus.rom_addr == 32'd1) t_cap1 = cyc;
    if (rom_mapped && !map_p) t_map = cyc;
    if (load_error && !err_p) t_err = cyc;
    map_p = rom_mapped;
    err_p = load_error;
    if (stall_mon) begin
      if (rom_bus.rom_read_en) bad_rd++;
      if (mem_we === 1'b1) bad_we++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    img_basic();
    do_reset();
    chk_rst("reset");
    wait_done("basic");
    chk("basic_fi", first_instruction, 32'h30);
    chk("basic_mapped", 32'(rom_mapped), 32'd1);
    chk("basic_err", 32'(load_error), 32'd0);
    chk("basic_map_lat", t_map - t_ff, 32'd1);
    chk("mem_00", 32'(mem[8'h00]), 32'h00);
    chk("mem_01", 32'(mem[8'h01]), 32'h61);
    chk("mem_AB", 32'(mem[8'hAB]), 32'(rom[8'hAB]));
    chk("basic_copy", copy_diffs(), 32'd0);
    chk("basic_reads", reads, 32'd256);
    chk("basic_writes", writes, 32'd256);

    img_basic();
    rom[1] = 8'h62;
    do_reset();
    wait_done("magic");
    chk("magic_err", 32'(load_error), 32'd1);
    chk("magic_lat", 32'(t_err > t_cap1 && t_err - t_cap1 <= 3), 32'd1);
    chk("magic_mapped", 32'(rom_mapped), 32'd0);
    chk("magic_reads", reads, 32'd2);
    chk("magic_rd_en", 32'(rom_bus.rom_read_en), 32'd0);
    chk("magic_fi", first_instruction, 32'd0);

    img_custom();
    do_reset();
    wait_done("custom");
    chk("custom_fi", first_instruction, 32'h92);
    chk("custom_err", 32'(load_error), 32'd0);
    chk("custom_mapped", 32'(rom_mapped), 32'd1);

    img_basic();
    for (int i = 52; i < 256; i++) rom[8'(i)] = 8'(i) ^ 8'h5A;
    do_reset();
    n = 0;
    while (!(rom_bus.rom_ready && rom_bus.rom_addr == 32'd100) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("stall_sync", 32'(n < 3000), 32'd1);
    @(posedge clk); #1;
    mem_grant = 1'b0;
    stall_mon = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_addr", rom_bus.rom_addr, 32'd100);
    stall_mon = 1'b0;
    mem_grant = 1'b1;
    wait_done("stall");
    chk("stall_rd", bad_rd, 32'd0);
    chk("stall_we", bad_we, 32'd0);
    chk("stall_copy", copy_diffs(), 32'd0);
    chk("stall_writes", writes, 32'd256);
    chk("stall_fi", first_instruction, 32'h30);
    chk("stall_err", 32'(load_error), 32'd0);

    img_basic();
    do_reset();
    repeat (120) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_rst("midrst");
    clear_tb();
    rst_n = 1'b1;
    wait_done("midrst");
    chk("midrst_fi", first_instruction, 32'h30);
    chk("midrst_mapped", 32'(rom_mapped), 32'd1);
    chk("midrst_err", 32'(load_error), 32'd0);
    chk("midrst_copy", copy_diffs(), 32'd0);

    put_hdr();
    do_reset();
    wait_done("nocode");
    chk("nocode_mapped", 32'(rom_mapped), 32'd1);
    chk("nocode_err", 32'(load_error), 32'd1);
    chk("nocode_fi", first_instruction, 32'd0);

    put_hdr();
    rom[8] = 8'h01;
    for (int i = 9; i < 14; i++) rom[8'(i)] = 8'h80;
    do_reset();
    wait_done("leb6");
    chk("leb6_err", 32'(load_error), 32'd1);
    chk("leb6_mapped", 32'(rom_mapped), 32'd0);
    chk("leb6_reads", reads, 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/wasm_image_loader.md
Name: wasm_image_loader

Overview:
- Boot-time loader between the program ROM and main memory.
- Streams a WebAssembly binary image byte by byte from ROM and copies every byte into memory at the same address.
- While streaming, parses the module structure to find the memory address of the first instruction of the first function body.
- Asserts rom_mapped when done, which hands the memory bus to the cpu.

Parameters:
- ROM_BYTES, 256, number of ROM bytes copied (addresses 0..ROM_BYTES-1).
- ADDR_W, 32, width of ROM and memory addresses.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rom_addr  out  ADDR_W  ROM byte address.
- rom_data  in  8  ROM read data, valid when rom_ready=1.
- rom_read_en  out  1  ROM read request.
- rom_ready  in  1  one-cycle pulse: rom_data valid.
- mem_grant  in  1  loader owns the shared memory bus this cycle.
- mem_addr  out  ADDR_W  memory write address; high-Z when mem_grant=0.
- mem_data  out  8  memory write data; high-Z when mem_grant=0.
- mem_write_en  out  1  memory write strobe; high-Z when mem_grant=0.
- rom_mapped  out  1  image fully copied and parsed; sticky.
- first_instruction  out  ADDR_W  address of first opcode of code-section body 0.
- load_error  out  1  malformed image detected; sticky.

Behaviour:
- Reset values: rom_addr=0, rom_read_en=0, rom_mapped=0, load_error=0, first_instruction=0. Internal mem_write_en=0; the pin is high-Z when not granted.
- Reset mid-load abandons the load and restarts from address 0 on the next cycle with rst_n=1.
- ROM handshake:
  - Drive rom_addr and rom_read_en=1, hold both until rom_ready.
  - Capture rom_data on the rom_ready cycle.
  - Drop rom_read_en for at least one cycle before the next request.
  - Addresses are strictly increasing, so every request is a new address.
- Copy:
  - For each captured byte at address A, issue one memory write: mem_addr=A, mem_data=byte, mem_write_en=1 for exactly one cycle.
  - The write happens only in a cycle with mem_grant=1. With mem_grant=0, hold the pending write (stall) and issue no further ROM reads.
  - Memory accepts a write in one cycle; there is no acknowledge.
- Parser: runs on the captured byte stream with these states:
  - HDR: bytes 0..7 must be 00 61 73 6D 01 00 00 00. Any mismatch sets load_error and stops the loader; rom_mapped stays 0.
  - SEC_ID: reads the section id.
  - SEC_SIZE: reads an unsigned LEB128 size, up to 5 bytes; bit7 means continuation; value is 32-bit.
  - SKIP: consumes size bytes when the id is not 10.
  - CODE_CNT: code section (id 10); reads the function-count LEB. A count of 0 sets load_error.
  - BODY_SIZE: reads the body-size LEB of body 0.
  - LOCAL_CNT: reads the local-group count LEB.
  - LOCAL_ENT: consumes N×(count LEB + 1 valtype byte).
  - Then first_instruction is latched to the address of the next byte, and the parser goes to DONE_PARSE, ignoring the rest of the stream.
  - Whenever a section ends (byte address reaches its end), return to SEC_ID.
- LEB128 with more than 5 bytes sets load_error.
- End of image: after the write of address ROM_BYTES-1 completes, set rom_mapped=1 on the following cycle. Also set load_error=1 if no code section was found; first_instruction then stays 0.
- After rom_mapped, the loader issues no ROM reads or memory writes until reset.
- ROM image bytes beyond the module end are copied verbatim and not parsed.

Decomposition:
- Shared package (wasm_pkg):
  - magic/version byte constants;
  - section id constants (SEC_CODE=10, plus 0..11);
  - parser state enum;
  - ADDR_W default.
- One sub-module: leb128_decoder. Byte-in/valid-in; outputs value[31:0], done and overflow; clear input for restart.

Test Plan:
- Header, then type section (id 1, size 5), then code section id 10 laid out so body 0 has 1 local group (count 1, type 0x7F) and its first opcode sits at 0x30; ROM zero-padded to 256 bytes → first_instruction=0x30, rom_mapped rises after write of 0xFF, load_error=0.
- Same image; then read memory at every address → equals ROM byte, e.g. mem[0x00]=0x00, mem[0x01]=0x61, mem[0xAB]=ROM[0xAB].
- Byte 1 = 0x62 (bad magic) → load_error=1 within 3 cycles of that byte's capture; rom_mapped stays 0; no further ROM reads.
- Custom section (id 0) with size encoded as 0x80 0x01 (=128) placed before the code section → skipped correctly; first_instruction = 8 + 1 + 2 + 128 + code offset.
- Deassert mem_grant for 10 cycles mid-copy → mem_addr/mem_data/mem_write_en are 'z, rom_read_en stays 0, no write lost or duplicated; copy completes identically.
- Pull rst_n low for 1 cycle during parsing → all outputs return to reset values; reload completes and yields first_instruction=0x30.
